nco_sweep_ctrl: RTL
===================

# nco_sweep_ctrl

Frequency-sweep controller that drives the `step` (phase increment) input of the LUT-based NCO. It produces a registered signed step word that ramps linearly between a programmed start and stop value. Each value is held for a programmable dwell, and the block supports single, sawtooth and triangle sweep modes. It sits directly upstream of the NCO and shares its clock, reset and active-low chip-select, so a deselected chip freezes both blocks together.

## Interface
Parameters:
- `ACC_SIZE`, 10: width of the step word; matches the NCO phase accumulator input.
- `DWELL_WIDTH`, 8: width of the dwell count.

Ports:
- `iclk`, in, 1: clock.
- `iresetn`, in, 1: reset, asynchronous, active-low.
- `inCS`, in, 1: active-low enable; when high, all state and outputs freeze.
- `istart`, in, 1: start pulse; sampled only when `inCS` = 0.
- `iabort`, in, 1: abort; takes priority over `istart`.
- `imode`, in, 2: 00 = single, 01 = sawtooth, 10 = triangle, 11 = reserved (treated as single).
- `istep_start`, in, ACC_SIZE, signed: first step value.
- `istep_stop`, in, ACC_SIZE, signed: final step value.
- `istep_inc`, in, ACC_SIZE-1, unsigned: increment magnitude.
- `idwell`, in, DWELL_WIDTH: extra enabled cycles each value is held, so each value lasts dwell+1 cycles.
- `ostep`, out, ACC_SIZE, signed: step word to the NCO; registered.
- `obusy`, out, 1: sweep in progress.
- `odone`, out, 1: one-cycle pulse when a single sweep completes.

## Operation
- Reset values: `ostep` = 0, `obusy` = 0, `odone` = 0, state IDLE, direction up.
- States are IDLE, SWEEP, FINISH.
- **IDLE**
  - On `istart`, latch start, stop, inc, dwell and mode into shadow registers.
  - Set `ostep` ← start, dwell counter ← dwell, direction ← up, go to SWEEP.
  - Outside a sweep, `ostep` holds its last value.
- **SWEEP**, each enabled cycle:
  - If the dwell counter ≠ 0, decrement it.
  - Otherwise reload the dwell counter and compute the next value: `ostep` ± inc, evaluated in ACC_SIZE+1 bits signed so it never wraps.
  - Going up, if next ≥ stop, clamp to stop. Going down, if next ≤ start, clamp to start.
- **Boundary reached**, i.e. the dwell at a clamped endpoint expires:
  - Single mode: go to FINISH.
  - Sawtooth mode: `ostep` ← start.
  - Triangle mode: flip direction and take a normal step away from the endpoint.
- **FINISH**: assert `odone` for one cycle, clear `obusy`, go to IDLE. `ostep` stays at stop.
- **Start > stop (signed)**: treated as stop = start. `ostep` = start for one dwell, then single mode finishes; other modes hold start indefinitely.
- **inc = 0**: `ostep` holds start indefinitely and `obusy` stays high until abort. Single mode never completes.
- **Abort**: `iabort` in any state forces IDLE next cycle, with `obusy` = 0, no `odone`, and `ostep` held.
- **Start while busy**: `istart` in SWEEP or FINISH is ignored. Input changes during a sweep have no effect because shadow registers are used.

## Timing
- `istart` in enabled cycle N gives `ostep` = start and `obusy` = 1 in cycle N+1.
- Each `ostep` value is visible for exactly dwell+1 enabled cycles.
- Single sweep: `odone` = 1 and `obusy` = 0 together, in the enabled cycle after the last stop dwell.
- Cycles with `inCS` = 1 are not counted and change no register.
- The NCO adds its own pipeline latency of 4 enabled cycles from `step` to `out`; that latency is not compensated here.
- Asserting `iresetn` mid-sweep returns every output to its reset value immediately.

## Structure
- Shared package `nco_pkg` holds:
  - the sweep mode enum and its encodings,
  - the state enum,
  - the default constants for `ACC_SIZE` and `DWELL_WIDTH`.
- One sub-module, `nco_dwell_timer`: a loadable down-counter with load, enable and an expire flag.
- The step arithmetic, clamping and FSM live in the top module.

## Test plan
- **Single sweep**: start = 0, stop = 10, inc = 4, dwell = 1, `istart` at cycle 0 → `ostep` = 0 in cycles 1–2, 4 in 3–4, 8 in 5–6, 10 in 7–8; `odone` pulse in cycle 9; `obusy` low from cycle 9.
- **Triangle**: start = −6, stop = 6, inc = 6, dwell = 0 → `ostep` repeats −6, 0, 6, 0, −6, 0, 6… with `obusy` held high.
- **Sawtooth with clamp**: start = 500, stop = 511, inc = 8, dwell = 0 → `ostep` 500, 508, 511, 500… with no overflow at the ACC_SIZE limit.
- **Freeze**: `inCS` held high for 5 cycles mid-dwell → `ostep` and the dwell count are frozen, and the sequence resumes unchanged afterwards.
- **Abort and restart**: `iabort` asserted together with `istart` → the block stays IDLE. `istart` during SWEEP is ignored. `iabort` during SWEEP → `obusy` = 0 next cycle, `ostep` held, no `odone`.
- **Degenerate inputs**: start = 5, stop = −3, single mode, dwell = 2 → `ostep` = 5 for 3 cycles, then `odone`. inc = 0 → `obusy` stays high for 100 cycles until aborted.

Source files
------------

// File: rtl/nco_pkg.sv
// nco_pkg: shared sweep-mode/state encodings and default widths for the NCO slice
package nco_pkg;
    localparam int ACC_SIZE_DEF    = 10;
    localparam int DWELL_WIDTH_DEF = 8;
    typedef enum logic [1:0] {
        MODE_SINGLE = 2'b00,
        MODE_SAW    = 2'b01,
        MODE_TRI    = 2'b10,
        MODE_RSVD   = 2'b11
    } sweep_mode_e;
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SWEEP  = 2'b01,
        ST_FINISH = 2'b10
    } sweep_state_e;
endpackage

// File: rtl/nco_dwell_timer.sv
// nco_dwell_timer: loadable down-counter that flags when the current dwell has expired
module nco_dwell_timer #(
    parameter int WIDTH = 8
) (
    input  logic             iclk,
    input  logic             iresetn,
    input  logic             iload,
    input  logic             ien,
    input  logic [WIDTH-1:0] ival,
    output logic             oexpire
);
    logic [WIDTH-1:0] r_cnt;
    always_ff @(posedge iclk or negedge iresetn)
        if (!iresetn) r_cnt <= '0;
        else if (iload) r_cnt <= ival;
        else if (ien && !oexpire) r_cnt <= r_cnt - WIDTH'(1);
    assign oexpire = (r_cnt == '0);
endmodule

// File: rtl/nco_sweep_ctrl.sv
// nco_sweep_ctrl: ramps the NCO step word between start and stop with per-value dwell
module nco_sweep_ctrl
    import nco_pkg::*;
#(
    parameter int ACC_SIZE    = ACC_SIZE_DEF,
    parameter int DWELL_WIDTH = DWELL_WIDTH_DEF
) (
    input  logic                       iclk,
    input  logic                       iresetn,
    input  logic                       inCS,
    input  logic                       istart,
    input  logic                       iabort,
    input  logic [1:0]                 imode,
    input  logic signed [ACC_SIZE-1:0] istep_start,
    input  logic signed [ACC_SIZE-1:0] istep_stop,
    input  logic [ACC_SIZE-2:0]        istep_inc,
    input  logic [DWELL_WIDTH-1:0]     idwell,
    output logic signed [ACC_SIZE-1:0] ostep,
    output logic                       obusy,
    output logic                       odone
);
    sweep_state_e               r_state, w_next;
    sweep_mode_e                r_mode;
    logic signed [ACC_SIZE-1:0] r_step, r_start, r_stop, w_clamp;
    logic [ACC_SIZE-2:0]        r_inc;
    logic [DWELL_WIDTH-1:0]     r_dwell;
    logic                       r_up, w_en, w_go, w_tick, w_expire, w_at_end, w_up, w_single;
    logic signed [ACC_SIZE:0]   w_sum, w_start_x, w_stop_x;

    assign w_en     = ~inCS;
    assign w_go     = (r_state == ST_IDLE) && istart && !iabort;
    assign w_tick   = (r_state == ST_SWEEP) && !iabort && w_expire;
    assign w_single = (r_mode == MODE_SINGLE) || (r_mode == MODE_RSVD);

    nco_dwell_timer #(.WIDTH(DWELL_WIDTH)) u_timer (
        .iclk    (iclk),
        .iresetn (iresetn),
        .iload   (w_en && (w_go || w_tick)),
        .ien     (w_en && (r_state == ST_SWEEP) && !iabort),
        .ival    (w_go ? idwell : r_dwell),
        .oexpire (w_expire)
    );

    // one extra bit so start/stop near the signed limits never wrap before clamping
    assign w_at_end  = r_up ? (r_step == r_stop) : (r_step == r_start);
    assign w_up      = (r_mode == MODE_TRI && w_at_end) ? !r_up : r_up;
    assign w_start_x = {r_start[ACC_SIZE-1], r_start};
    assign w_stop_x  = {r_stop[ACC_SIZE-1], r_stop};
    assign w_sum     = w_up ? {r_step[ACC_SIZE-1], r_step} + {2'b00, r_inc}
                            : {r_step[ACC_SIZE-1], r_step} - {2'b00, r_inc};
    assign w_clamp   = w_up ? ((w_sum >= w_stop_x) ? r_stop : w_sum[ACC_SIZE-1:0])
                            : ((w_sum <= w_start_x) ? r_start : w_sum[ACC_SIZE-1:0]);

    always_ff @(posedge iclk or negedge iresetn)
        if (!iresetn) r_state <= ST_IDLE;
        else if (w_en) r_state <= w_next;

    always_comb begin
        w_next = r_state;
        if (iabort) w_next = ST_IDLE;
        else if (r_state == ST_IDLE) w_next = istart ? ST_SWEEP : ST_IDLE;
        else if (r_state == ST_FINISH) w_next = ST_IDLE;
        else if (w_expire && w_at_end && w_single) w_next = ST_FINISH;
    end

    always_comb begin
        obusy = (r_state == ST_SWEEP);
        odone = (r_state == ST_FINISH);
    end

    // start > stop collapses the ramp onto start
    always_ff @(posedge iclk or negedge iresetn)
        if (!iresetn) begin
            r_step  <= '0;
            r_start <= '0;
            r_stop  <= '0;
            r_inc   <= '0;
            r_dwell <= '0;
            r_mode  <= MODE_SINGLE;
            r_up    <= 1'b1;
        end else if (w_en) begin
            if (w_go) begin
                r_start <= istep_start;
                r_stop  <= (istep_start > istep_stop) ? istep_start : istep_stop;
                r_inc   <= istep_inc;
                r_dwell <= idwell;
                r_mode  <= sweep_mode_e'(imode);
                r_step  <= istep_start;
                r_up    <= 1'b1;
            end else if (w_tick) begin
                r_up    <= w_up;
                r_step  <= (w_at_end && r_mode == MODE_SAW) ? r_start :
                           (w_at_end && w_single) ? r_step : w_clamp;
            end
        end

    assign ostep = r_step;
endmodule
